// File: rtl/e_mdu_ctrl_pkg.sv
// e_mdu_ctrl_pkg: shared MDU opcodes, FSM state type and opcode classifiers.
// The MDU_* opcodes are 4 bits wide and shared with the decode stage.
package e_mdu_ctrl_pkg;

  localparam int unsigned MduOpW = 4;
  typedef logic [MduOpW-1:0] mdu_op_t;

  localparam mdu_op_t MDU_NONE  = 4'd0;
  localparam mdu_op_t MDU_MULT  = 4'd1;
  localparam mdu_op_t MDU_MULTU = 4'd2;
  localparam mdu_op_t MDU_DIV   = 4'd3;
  localparam mdu_op_t MDU_DIVU  = 4'd4;
  localparam mdu_op_t MDU_MTHI  = 4'd5;
  localparam mdu_op_t MDU_MTLO  = 4'd6;
  localparam mdu_op_t MDU_MFHI  = 4'd7;
  localparam mdu_op_t MDU_MFLO  = 4'd8;

  typedef enum logic [0:0] {StIdle, StRun} mdu_state_t;

  function automatic logic is_mul(mdu_op_t op);
    return (op == MDU_MULT) || (op == MDU_MULTU);
  endfunction

  function automatic logic is_div(mdu_op_t op);
    return (op == MDU_DIV) || (op == MDU_DIVU);
  endfunction

endpackage

// File: rtl/e_mdu_ctrl_if.sv
// e_mdu_ctrl_if: E-stage <-> MDU signal bundle.
//   Start, MDUOp, A, B : requests from the E stage (master drives)
//   Busy, HI, LO, Out  : MDU status, architectural HI/LO and read data (slave drives)
interface e_mdu_ctrl_if;
  import e_mdu_ctrl_pkg::*;

  logic        Start;
  mdu_op_t     MDUOp;
  logic [31:0] A;
  logic [31:0] B;
  logic        Busy;
  logic [31:0] HI;
  logic [31:0] LO;
  logic [31:0] Out;

  modport master (output Start, MDUOp, A, B, input Busy, HI, LO, Out);
  modport slave  (input Start, MDUOp, A, B, output Busy, HI, LO, Out);
endinterface

// File: rtl/e_mdu_arith.sv
// e_mdu_arith: combinational MDU datapath.
//   op, a, b  : latched operation and operands
//   res       : {hi, lo} result (product, or {remainder, quotient})
//   div_zero  : divide op with zero divisor; caller must not commit
// The divider exists only when MDU_DIV_EN is defined; otherwise div ops yield 0.
module e_mdu_arith
  import e_mdu_ctrl_pkg::*;
(
  input  mdu_op_t     op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [63:0] res,
  output logic        div_zero
);

`ifdef MDU_DIV_EN
  // Single unsigned divider on magnitudes; signs are restored afterwards so
  // the quotient truncates toward zero and the remainder follows the dividend.
  logic        sgn;
  logic [31:0] num, den, q_mag, r_mag, quo, rem;

  always_comb begin
    sgn   = (op == MDU_DIV);
    num   = (sgn && a[31]) ? -a : a;
    den   = (sgn && b[31]) ? -b : b;
    if (den == 32'd0) den = 32'd1;  // keeps the divider X-free; result discarded
    q_mag = num / den;
    r_mag = num % den;
    quo   = (sgn && (a[31] ^ b[31])) ? -q_mag : q_mag;
    rem   = (sgn && a[31]) ? -r_mag : r_mag;
  end
`endif

  always_comb begin
    res      = '0;
    div_zero = 1'b0;
    case (op)
      MDU_MULT:  res = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
      MDU_MULTU: res = {32'd0, a} * {32'd0, b};
`ifdef MDU_DIV_EN
      MDU_DIV, MDU_DIVU: begin
        res      = {rem, quo};
        div_zero = (b == 32'd0);
      end
`endif
      default: res = '0;
    endcase
  end

endmodule

// File: rtl/e_mdu_ctrl.sv
// e_mdu_ctrl: multi-cycle multiply/divide controller for the E stage.
//   clk, reset : clock and synchronous active-high reset
//   mdu        : slave side of e_mdu_ctrl_if (Start/MDUOp/A/B in; Busy/HI/LO/Out out)
// Build option: define MDU_DIV_EN to include div/divu; without it a div Start is ignored.
module e_mdu_ctrl
  import e_mdu_ctrl_pkg::*;
#(
  parameter int unsigned MDU_MUL_CYCLES = 5,
  parameter int unsigned MDU_DIV_CYCLES = 10
) (
  input logic          clk,
  input logic          reset,
  e_mdu_ctrl_if.slave  mdu
);

  localparam int unsigned MaxLat = (MDU_MUL_CYCLES > MDU_DIV_CYCLES) ?
                                   MDU_MUL_CYCLES : MDU_DIV_CYCLES;
  localparam int unsigned CntW   = ($clog2(MaxLat + 1) < 4) ? 4 : $clog2(MaxLat + 1);

  mdu_state_t      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  mdu_op_t         op_q, op_d;
  logic [31:0]     a_q, a_d, b_q, b_d;
  logic [31:0]     hi_q, hi_d, lo_q, lo_d;

  logic        launch_mul, launch_div;
  logic [63:0] res;
  logic        div_zero;

  assign launch_mul = mdu.Start && is_mul(mdu.MDUOp);
`ifdef MDU_DIV_EN
  assign launch_div = mdu.Start && is_div(mdu.MDUOp);
`else
  assign launch_div = 1'b0;
`endif

  e_mdu_arith u_arith (
    .op       (op_q),
    .a        (a_q),
    .b        (b_q),
    .res      (res),
    .div_zero (div_zero)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    unique case (state_q)
      StIdle: begin
        if (launch_mul || launch_div) begin
          op_d    = mdu.MDUOp;
          a_d     = mdu.A;
          b_d     = mdu.B;
          cnt_d   = launch_div ? CntW'(MDU_DIV_CYCLES) : CntW'(MDU_MUL_CYCLES);
          state_d = StRun;
        end else if (mdu.MDUOp == MDU_MTHI) begin
          hi_d = mdu.A;
        end else if (mdu.MDUOp == MDU_MTLO) begin
          lo_d = mdu.A;
        end
      end
      StRun: begin
        // Requests arriving here are ignored by construction.
        cnt_d = cnt_q - CntW'(1);
        if (cnt_q == CntW'(1)) begin
          state_d = StIdle;
          if (!div_zero) begin
            hi_d = res[63:32];
            lo_d = res[31:0];
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      op_q    <= MDU_NONE;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign mdu.Busy = (state_q == StRun);
  assign mdu.HI   = hi_q;
  assign mdu.LO   = lo_q;
  // Reads see pre-commit values: no bypass from the arithmetic result.
  assign mdu.Out  = (mdu.MDUOp == MDU_MFHI) ? hi_q :
                    (mdu.MDUOp == MDU_MFLO) ? lo_q : 32'd0;

endmodule
